turn_sequencer: RTL
===================

// Module: turn_sequencer
// PURPOSE
//  Game controller in front of the nine-square board array. Accepts move requests
//  over a valid/ready handshake, validates them against board state, and issues a
//  one-cycle one-hot mark pulse with the current player. It then checks the board
//  for win/draw and alternates turns, with an optional per-turn timeout (forfeit).
// PARAMETERS
//  FIRST_PLAYER  1'b0  player who moves first after reset (0 = X, 1 = O)
//  TIMEOUT       0     cycles allowed per turn in IDLE; 0 disables the timeout
//  TO_W          16    width of turn-timer counter; TIMEOUT must be < 2**TO_W
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous reset, active-low
//  move_valid  in   1   move request valid
//  move_idx    in   4   requested square 0..8 (row-major)
//  move_ready  out  1   sequencer can accept a move this cycle
//  marked      in   9   per-square occupied flags from board array
//  owner       in   9   per-square owner from board array (valid where marked=1)
//  error       in   9   per-square error flags from board array
//  mark        out  9   one-hot mark pulse to board array
//  player      out  1   player whose turn it is; drives board array player input
//  reject      out  1   1-cycle pulse: accepted move was illegal
//  forfeit     out  1   1-cycle pulse: turn timed out, turn passed to other player
//  game_over   out  1   game finished (win, draw or fault); sticky until rst
//  winner_vld  out  1   game_over due to three-in-a-row
//  winner      out  1   winning player (valid when winner_vld)
//  fault       out  1   board reported error; sticky until rst
//  move_cnt    out  4   number of successfully placed marks, 0..9
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, player=FIRST_PLAYER, mark=0, reject=0,
//   forfeit=0, game_over=0, winner_vld=0, winner=0, fault=0, move_cnt=0, timer=0.
//  States: IDLE -> ISSUE -> SETTLE -> CHECK -> {IDLE | OVER}. All outputs registered.
//  IDLE: move_ready=1 iff state==IDLE and !game_over. Transfer on move_valid&&move_ready.
//   - move_idx>8 or marked[move_idx]=1: reject=1 next cycle; stay IDLE; player unchanged.
//   - otherwise: latch idx, go ISSUE.
//   - timer counts cycles in IDLE; cleared on any transfer or turn change. If TIMEOUT!=0
//     and timer reaches TIMEOUT-1 with no transfer: forfeit=1, player toggles, timer=0.
//     Transfer in the timeout cycle wins: move is processed, no forfeit.
//  ISSUE: mark = 1<<idx for exactly one cycle; player held stable. move_ready=0.
//  SETTLE: mark=0; one cycle for board array to register the mark.
//  CHECK: move_cnt+1. Evaluate 8 lines (3 rows, 3 cols, 2 diags) on marked/owner.
//   - any error bit set (sampled in SETTLE or CHECK): fault=1, game_over=1 -> OVER.
//   - line of 3 marked squares with equal owner: winner_vld=1, winner=owner -> OVER.
//   - else move_cnt==9 (after increment): game_over=1, winner_vld=0 (draw) -> OVER.
//   - else player toggles, timer=0 -> IDLE.
//   Priority: fault > win > draw.
//  OVER: terminal; move_ready=0, mark=0; ignores move_valid and timer. Exit only by rst.
//  Latency: accepted legal move -> mark pulse 1 cycle later; next move_ready 4 cycles
//   after acceptance. Illegal move -> reject 1 cycle later; move_ready stays 1.
//  move_cnt saturates at 9; never wraps.
//  error asserted in IDLE: fault=1, game_over=1 next cycle -> OVER.
//  rst low mid-ISSUE: mark drops to 0 asynchronously; no partial state retained.
// STRUCTURE
//  Package game_pkg: NUM_SQ=9; state enum {IDLE,ISSUE,SETTLE,CHECK,OVER}; constant
//   table LINES[8] of 3 square indices each; player encodings P_X=0, P_O=1.
//  Sub-module line_checker (combinational): in marked[8:0], owner[8:0];
//   out win, win_player. The FSM, timer and output registers remain in turn_sequencer.
// TESTING
//  1 X: 0,3,1,4,2 (O interleaved) -> mark pulses 001h,008h,002h,010h,004h;
//    player 0,1,0,1,0; after last CHECK winner_vld=1, winner=0, move_cnt=5.
//  2 Occupied square: X plays 4, O requests 4 -> reject 1 cycle, player stays 1,
//    no mark pulse; O then plays 0 -> accepted, mark=001h.
//  3 move_idx=9..15 -> reject each time; move_cnt unchanged; move_ready stays 1.
//  4 Draw: X4,O0,X2,O6,X3,O5,X1,O7,X8 -> game_over=1, winner_vld=0, move_cnt=9;
//    further move_valid ignored, move_ready=0.
//  5 TIMEOUT=10, no move for 10 cycles -> forfeit pulse, player 0->1; move at
//    cycle 9 of next turn -> accepted, no forfeit.
//  6 Force error[5]=1 during SETTLE -> fault=1, game_over=1; assert rst mid-ISSUE
//    -> mark=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// Shared board geometry, FSM state type and player encodings for the turn sequencer.
package game_pkg;

  localparam int NUM_SQ = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    OVER   = 3'd4
  } state_e;

  localparam logic P_X = 1'b0;
  localparam logic P_O = 1'b1;

  // Rows, columns, then the two diagonals, as row-major square indices.
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/turn_sequencer_if.sv
// Move-request handshake between a requester and the turn sequencer.
interface turn_sequencer_if;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;

  modport master (output move_valid, output move_idx, input  move_ready);
  modport slave  (input  move_valid, input  move_idx, output move_ready);
endinterface

// File: rtl/turn_sequencer_line_checker.sv
// Combinational three-in-a-row detector over the board occupancy/owner vectors.
module line_checker
  import game_pkg::*;
(
  input  logic [NUM_SQ-1:0] marked,
  input  logic [NUM_SQ-1:0] owner,
  output logic              win,
  output logic              win_player
);

  always_comb begin
    win        = 1'b0;
    win_player = P_X;
    for (int unsigned l = 0; l < 8; l++) begin
      if (marked[LINES[l][0]] && marked[LINES[l][1]] && marked[LINES[l][2]] &&
          (owner[LINES[l][0]] == owner[LINES[l][1]]) &&
          (owner[LINES[l][1]] == owner[LINES[l][2]])) begin
        win        = 1'b1;
        win_player = owner[LINES[l][0]];
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn controller: validates moves, pulses the board mark,
// then resolves win/draw/fault and alternates players with an optional turn timeout.
module turn_sequencer
  import game_pkg::*;
#(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter int   TIMEOUT      = 0,
  parameter int   TO_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  turn_sequencer_if.slave     mv,
  input  logic [NUM_SQ-1:0]   marked,
  input  logic [NUM_SQ-1:0]   owner,
  input  logic [NUM_SQ-1:0]   error,
  output logic [NUM_SQ-1:0]   mark,
  output logic                player,
  output logic                reject,
  output logic                forfeit,
  output logic                game_over,
  output logic                winner_vld,
  output logic                winner,
  output logic                fault,
  output logic [3:0]          move_cnt
);

  state_e             state_q, state_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [NUM_SQ-1:0]  mark_q, mark_d;
  logic               err_q, err_d;
  logic               player_q, player_d;
  logic               reject_q, reject_d;
  logic               forfeit_q, forfeit_d;
  logic               game_over_q, game_over_d;
  logic               winner_vld_q, winner_vld_d;
  logic               winner_q, winner_d;
  logic               fault_q, fault_d;
  logic [3:0]         cnt_q, cnt_d;

  logic               move_ready;
  logic               transfer;
  logic               illegal;
  logic               line_win;
  logic               line_player;
  logic [3:0]         cnt_inc;

  line_checker u_lines (
    .marked     (marked),
    .owner      (owner),
    .win        (line_win),
    .win_player (line_player)
  );

  assign move_ready    = (state_q == IDLE) && !game_over_q;
  assign mv.move_ready = move_ready;
  assign transfer      = mv.move_valid && move_ready;
  assign illegal       = (mv.move_idx > 4'd8) || marked[mv.move_idx];
  assign cnt_inc       = (cnt_q >= 4'd9) ? 4'd9 : cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mark_d       = '0;
    err_d        = err_q;
    player_d     = player_q;
    reject_d     = 1'b0;
    forfeit_d    = 1'b0;
    game_over_d  = game_over_q;
    winner_vld_d = winner_vld_q;
    winner_d     = winner_q;
    fault_d      = fault_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (|error) begin
          fault_d     = 1'b1;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else if (transfer) begin
          timer_d = '0;
          if (illegal) begin
            reject_d = 1'b1;
          end else begin
            // The registered one-hot mark doubles as the latched move index.
            mark_d  = NUM_SQ'(1) << mv.move_idx;
            state_d = ISSUE;
          end
        end else if ((TIMEOUT != 0) && (timer_q == TO_W'(TIMEOUT - 1))) begin
          forfeit_d = 1'b1;
          player_d  = (player_q == P_X) ? P_O : P_X;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ISSUE: begin
        err_d   = 1'b0;
        state_d = SETTLE;
      end
      SETTLE: begin
        err_d   = |error;
        state_d = CHECK;
      end
      CHECK: begin
        cnt_d = cnt_inc;
        if (err_q || (|error)) begin
          fault_d     = 1'b1;
          game_over_d = 1'b1;
          state_d     = OVER;
        end else if (line_win) begin
          winner_vld_d = 1'b1;
          winner_d     = line_player;
          game_over_d  = 1'b1;
          state_d      = OVER;
        end else if (cnt_inc == 4'd9) begin
          game_over_d = 1'b1;
          state_d     = OVER;
        end else begin
          player_d = (player_q == P_X) ? P_O : P_X;
          timer_d  = '0;
          state_d  = IDLE;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      mark_q       <= '0;
      err_q        <= 1'b0;
      player_q     <= FIRST_PLAYER;
      reject_q     <= 1'b0;
      forfeit_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_vld_q <= 1'b0;
      winner_q     <= 1'b0;
      fault_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      mark_q       <= mark_d;
      err_q        <= err_d;
      player_q     <= player_d;
      reject_q     <= reject_d;
      forfeit_q    <= forfeit_d;
      game_over_q  <= game_over_d;
      winner_vld_q <= winner_vld_d;
      winner_q     <= winner_d;
      fault_q      <= fault_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mark       = mark_q;
  assign player     = player_q;
  assign reject     = reject_q;
  assign forfeit    = forfeit_q;
  assign game_over  = game_over_q;
  assign winner_vld = winner_vld_q;
  assign winner     = winner_q;
  assign fault      = fault_q;
  assign move_cnt   = cnt_q;

endmodule
